hdmi_frame_sequencer: RTL

//  Generates video timing (hdmi_vs/hdmi_hs/hdmi_de) and a pixel fetch stream for HDMI-style

---
 rtl/hdmi_timing_pkg.sv | 28 ++
 rtl/video_delay_line.sv | 27 ++
 rtl/hdmi_frame_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI frame sequencer: default 64x64 geometry,
// the sequencer FSM encoding and the field layout of a 32-bit pixel.
package hdmi_timing_pkg;

  // Default frame geometry
  localparam int DEF_H_ACTIVE = 64;
  localparam int DEF_V_ACTIVE = 64;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_HS_W     = 4;
  localparam int DEF_V_BLANK  = 4;
  localparam int DEF_RD_LAT   = 2;

  // Pixel word layout: [31:24] unused pass-through, [23:16] R, [15:8] G, [7:0] B
  localparam int PIX_W = 32;
  localparam int CH_W  = 8;
  localparam int X_LSB = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register that delays a bundle of timing bits so they
// line up with pixel data returned by a fixed-latency source.
module video_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // Shift the bundle one stage per clock; reset clears every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_frame_sequencer.sv
// HDMI frame sequencer: raster counters, pixel fetch address generator,
// run/drain FSM and the output register that joins delayed timing with the
// fetched pixel data.
//
// Fetch contract: pix_rd is a one-cycle strobe per active pixel with no
// back-pressure; the source must present pix_data exactly RD_LAT cycles
// after the strobe. pix_addr is meaningful while pix_rd=1 and otherwise
// holds the last issued address.
module hdmi_frame_sequencer
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int HS_W     = DEF_HS_W,
  parameter int V_BLANK  = DEF_V_BLANK,
  parameter int RD_LAT   = DEF_RD_LAT,
  localparam int AW      = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic             hdmi_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       frames,
  output logic             pix_rd,
  output logic [AW-1:0]    pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic             hdmi_vs,
  output logic             hdmi_hs,
  output logic             hdmi_de,
  output logic [PIX_W-1:0] hdmi_data,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output state_t           state
);

  // Frame geometry: one lead-in line, the active lines, then vs-low blank lines
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = 1 + V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(RD_LAT + 2);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + HS_W);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_FIRST    = VW'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT);

  state_t        state_d;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [7:0]    remaining;
  logic [DW-1:0] drain_cnt;
  logic          load_remaining;
  logic          dec_remaining;
  logic          run;
  logic          frame_end;

  logic          vs_raw;
  logic          hs_raw;
  logic          de_raw;
  logic [AW-1:0] addr_calc;
  logic [AW-1:0] addr_hold;

  logic [2:0]       dly;
  logic             dly_vs;
  logic             dly_hs;
  logic             dly_de;
  logic [PIX_W-1:0] out_pix;
  logic             vs_fall;

  assign run       = (state == ST_RUN);
  assign frame_end = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign busy      = (state != ST_IDLE);

  // State register
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic: start on en, decide continue/stop only at frame boundaries
  always_comb begin
    state_d        = state;
    load_remaining = 1'b0;
    dec_remaining  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_d        = ST_RUN;
          load_remaining = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (!en || (remaining == 8'd1)) state_d = ST_DRAIN;
          else if (remaining != 8'd0)      dec_remaining = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frames-left counter; zero means free-run and is never decremented
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)              remaining <= 8'd0;
    else if (load_remaining) remaining <= frames;
    else if (dec_remaining)  remaining <= remaining - 8'd1;
  end

  // Drain timer: counts the cycles spent flushing the output pipeline
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)                 drain_cnt <= '0;
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt + DW'(1);
    else                        drain_cnt <= '0;
  end

  // Raster counters: held at zero outside RUN, free-running inside it
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Undelayed timing decoded from the counters; line 0 is a vs-high lead-in
  always_comb begin
    vs_raw = run && (v_cnt <= V_ACT);
    hs_raw = run && (h_cnt >= H_ACT) && (h_cnt < HS_END);
    de_raw = run && (v_cnt >= V_FIRST) && (v_cnt <= V_ACT) && (h_cnt < H_ACT);
  end

  // Raster address of the pixel being fetched this cycle
  assign addr_calc = AW'((32'(v_cnt) - 32'd1) * 32'(H_ACTIVE) + 32'(h_cnt));

  // Remember the last issued address so pix_addr is stable between fetches
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)      addr_hold <= '0;
    else if (de_raw) addr_hold <= addr_calc;
  end

  assign pix_rd   = de_raw;
  assign pix_addr = de_raw ? addr_calc : addr_hold;

  // Delay the timing bundle by the source read latency
  video_delay_line #(
    .W     (3),
    .DEPTH (RD_LAT)
  ) u_timing_dly (
    .clk   (hdmi_clk),
    .rst_n (rst_n),
    .din   ({vs_raw, hs_raw, de_raw}),
    .dout  (dly)
  );

  assign dly_vs = dly[2];
  assign dly_hs = dly[1];
  assign dly_de = dly[0];

  // Pixel presented to the sink: source fields during active video, black otherwise
  always_comb begin
    out_pix = '0;
    if (dly_de) begin
      out_pix[X_LSB +: CH_W] = pix_data[X_LSB +: CH_W];
      out_pix[R_LSB +: CH_W] = pix_data[R_LSB +: CH_W];
      out_pix[G_LSB +: CH_W] = pix_data[G_LSB +: CH_W];
      out_pix[B_LSB +: CH_W] = pix_data[B_LSB +: CH_W];
    end
  end

  // Frame completes when the outgoing vs is high and the delayed vs is low
  assign vs_fall = hdmi_vs & ~dly_vs;

  // Output register: timing, pixel and frame bookkeeping leave together
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      hdmi_vs    <= 1'b0;
      hdmi_hs    <= 1'b0;
      hdmi_de    <= 1'b0;
      hdmi_data  <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      hdmi_vs    <= dly_vs;
      hdmi_hs    <= dly_hs;
      hdmi_de    <= dly_de;
      hdmi_data  <= out_pix;
      frame_done <= vs_fall;
      if (vs_fall) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
